reg_file_wb: RTL and testbench

- 32x32 general-purpose register file for the single-cycle MIPS datapath.
- Sources the ALU operands: rs_data_o feeds src1_i and rt_data_o feeds src2_i.
- Sinks the write-back result: the ALU result_o (or memory data, via the writeback mux) arrives on rd_data_i.
- Two asynchronous read ports and one synchronous write port; register 0 is hardwired to zero; optional same-cycle write-to-read bypass.

---
 rtl/reg_file_wb.sv | 59 +++++
 tb/tb_reg_file_wb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - 2**ADDR_W x DATA_W register file, two async read ports, one sync write port.
// Register 0 reads as zero; register 29 resets to SP_INIT; optional same-cycle write-to-read bypass.
module reg_file_wb #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 5,
    parameter logic [DATA_W-1:0] SP_INIT = 32'd128,
    parameter int                BYPASS  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              reg_write_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int SP_IX = 29;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_en;

    // Reset blocks both the write and the bypass so reads show reset contents.
    assign wr_en = reg_write_i && !rst_i && (rd_addr_i != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IX) ? SP_INIT : '0;
            end
        end else if (wr_en) begin
            regs[rd_addr_i] <= rd_data_i;
        end
    end

    always_comb begin
        rs_data_o = regs[rs_addr_i];
        if ((BYPASS != 0) && wr_en && (rs_addr_i == rd_addr_i)) begin
            rs_data_o = rd_data_i;
        end
        if (rs_addr_i == '0) begin
            rs_data_o = '0;
        end
    end

    always_comb begin
        rt_data_o = regs[rt_addr_i];
        if ((BYPASS != 0) && wr_en && (rt_addr_i == rd_addr_i)) begin
            rt_data_o = rd_data_i;
        end
        if (rt_addr_i == '0) begin
            rt_data_o = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - directed scoreboard bench for reg_file_wb, BYPASS=1 and BYPASS=0 side by side.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data = '0;
    logic        reg_write = 1'b0;
    logic [31:0] rs_b, rt_b, rs_n, rt_n;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] model [32];

    always #5 clk = ~clk;

    reg_file_wb #(.BYPASS(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
        .rd_addr_i(rd_addr), .rd_data_i(rd_data), .reg_write_i(reg_write),
        .rs_data_o(rs_b), .rt_data_o(rt_b)
    );

    reg_file_wb #(.BYPASS(0)) dut_n (
        .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
        .rd_addr_i(rd_addr), .rd_data_i(rd_data), .reg_write_i(reg_write),
        .rs_data_o(rs_n), .rt_data_o(rt_n)
    );

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] ctrl);
        case (ctrl)
            4'b0000: alu = a & b;
            4'b0001: alu = a | b;
            4'b0010: alu = a + b;
            4'b0110: alu = a - b;
            4'b0111: alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: alu = '0;
        endcase
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (model[i]) model[i] = '0;
        model[29] = 32'd128;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1'b1;
        rd_addr   = a;
        rd_data   = d;
        tick();
        reg_write = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;

        // Asynchronous reset mid-cycle, with a write to r29 pending that must be ignored.
        #7;
        reg_write = 1'b1; rd_addr = 5'd29; rd_data = 32'h1;
        rst = 1'b1;
        rs_addr = 5'd29; rt_addr = 5'd5;
        #1;
        model_reset();
        push("rst_r29_b", 32'd128); check(rs_b);
        push("rst_r5_b", 32'd0);    check(rt_b);
        push("rst_r29_n", 32'd128); check(rs_n);
        push("rst_r5_n", 32'd0);    check(rt_n);
        reg_write = 1'b0;
        #1 rst = 1'b0;

        wr(5'd5, 32'hDEADBEEF);
        push("r5_after_release_b", 32'hDEADBEEF); check(rt_b);
        push("r5_after_release_n", 32'hDEADBEEF); check(rt_n);

        // Register 0 immunity, before and after the edge.
        reg_write = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        push("r0_same_cycle_b", 32'd0); check(rs_b);
        tick();
        reg_write = 1'b0;
        #1;
        push("r0_after_b", 32'd0); check(rs_b);
        push("r0_after_n", 32'd0); check(rs_n);

        // Bypass versus stored value.
        wr(5'd8, 32'd7);
        reg_write = 1'b1; rd_addr = 5'd8; rd_data = 32'd42;
        rs_addr = 5'd8; rt_addr = 5'd8;
        #1;
        push("bypass_rs_b", 32'd42); check(rs_b);
        push("bypass_rt_b", 32'd42); check(rt_b);
        push("nobypass_rs_n", 32'd7); check(rs_n);
        push("nobypass_rt_n", 32'd7); check(rt_n);
        tick();
        reg_write = 1'b0;
        model[8] = 32'd42;
        #1;
        push("r8_after_n", 32'd42); check(rs_n);
        push("r8_after_b", 32'd42); check(rs_b);

        // Write-enable gating.
        reg_write = 1'b0; rd_addr = 5'd3; rd_data = 32'd99;
        rs_addr = 5'd3;
        tick();
        push("we0_r3_b", 32'd0); check(rs_b);
        push("we0_r3_n", 32'd0); check(rs_n);
        wr(5'd3, 32'd99);
        push("we1_r3_n", 32'd99); check(rs_n);

        for (int a = 0; a < 32; a++) begin
            rs_addr = a[4:0];
            rt_addr = a[4:0];
            #1;
            push($sformatf("sweep_rs_b_r%0d", a), model[a]); check(rs_b);
            push($sformatf("sweep_rt_n_r%0d", a), model[a]); check(rt_n);
        end

        // Reset arriving while a write is pending: reset wins.
        wr(5'd10, 32'd5);
        reg_write = 1'b1; rd_addr = 5'd10; rd_data = 32'd6;
        rs_addr = 5'd10; rt_addr = 5'd29;
        #2 rst = 1'b1;
        tick();
        model_reset();
        push("midrst_r10_b", 32'd0);    check(rs_b);
        push("midrst_r10_n", 32'd0);    check(rs_n);
        push("midrst_r29_b", 32'd128);  check(rt_b);
        #2 rst = 1'b0;
        tick();
        reg_write = 1'b0;
        model[10] = 32'd6;
        #1;
        push("post_rst_r10_n", 32'd6); check(rs_n);
        push("post_rst_r10_b", 32'd6); check(rs_b);

        // ALU loop: r3 = r1 - r2, then r3 + r3.
        wr(5'd1, 32'd15);
        wr(5'd2, 32'd10);
        rs_addr = 5'd1; rt_addr = 5'd2;
        #1;
        res = alu(rs_b, rt_b, 4'b0110);
        push("alu_sub", 32'd5); check(res);
        wr(5'd3, res);
        rs_addr = 5'd3; rt_addr = 5'd3;
        #1;
        push("alu_r3_n", 32'd5); check(rs_n);
        res = alu(rs_b, rt_b, 4'b0010);
        push("alu_add", 32'd10); check(res);
        wr(5'd4, res);
        rs_addr = 5'd4;
        #1;
        push("alu_r4_n", 32'd10); check(rs_n);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
